uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Downstream consumer of the UART receive FIFO. Pops bytes, hunts for a frame
//  header, then assembles command frames for the RSA core: SOF, CMD, LEN,
//  LEN payload bytes, CHK. Checks the checksum and presents each good frame on
//  a valid/ready interface. Also reports framing errors.
// PARAMETERS
//  DBIT     8          UART data width (fixed 8 for framing)
//  MAX_LEN  16         max payload bytes per frame
//  SOF      8'hA5      start-of-frame byte
//  TO_CYC   1_000_000  inter-byte timeout in clk cycles (mid-frame only)
// PORTS
//  clk          in   1          system clock
//  reset_n      in   1          asynchronous active-low reset
//  r_data       in   DBIT       rx FIFO head byte (show-ahead: valid while !rx_empty)
//  rx_empty     in   1          rx FIFO empty
//  rd_uart      out  1          rx FIFO pop strobe (combinational)
//  cmd_valid    out  1          frame available
//  cmd_ready    in   1          consumer accepts frame
//  cmd_code     out  8          CMD byte
//  cmd_len      out  8          payload length, 0..MAX_LEN
//  cmd_payload  out  8*MAX_LEN  payload; byte i at [8i+7:8i], unused bytes 0
//  err_chk      out  1          1-cycle pulse: checksum mismatch
//  err_len      out  1          1-cycle pulse: LEN > MAX_LEN
//  err_timeout  out  1          1-cycle pulse: inter-byte timeout
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. Payload/len/code/checksum/timer cleared.
//  - rd_uart = !rx_empty && state != HOLD. One byte is consumed per popping cycle.
//  - FSM (advances only on pop, except timeout and HOLD):
//    IDLE: byte==SOF -> CMD, else discard silently (stay).
//    CMD: latch cmd_code, chk<=byte -> LEN.
//    LEN: chk^=byte; byte>MAX_LEN -> err_len, IDLE.
//      byte==0 -> CHK. Else clear payload, idx<=0 -> PAYLOAD.
//    PAYLOAD: store at idx, chk^=byte, idx++. Last byte (idx==len-1) -> CHK.
//    CHK: byte==chk -> HOLD (cmd_valid<=1). Else err_chk, IDLE.
//    HOLD: no pops. cmd_valid && cmd_ready -> cmd_valid<=0, IDLE. Popping
//      resumes next cycle.
//  - Checksum = XOR of CMD, LEN and all payload bytes (SOF excluded).
//  - Latency: CHK byte popped in cycle N -> cmd_valid high in cycle N+1.
//  - cmd_code/len/payload are stable while cmd_valid=1. Backpressure reaches
//    the UART solely by leaving bytes in the FIFO.
//  - Timeout: timer active in CMD/LEN/PAYLOAD/CHK. It clears on every pop and
//    increments when rx_empty. At TO_CYC-1: err_timeout pulse -> IDLE.
//    The timer is idle and cleared in IDLE and HOLD.
//  - SOF value mid-frame is treated as data (no resync).
//  - Error pulses are registered and last exactly 1 cycle; at most one per cycle.
//  - Async reset mid-frame: partial frame dropped, no error pulse.
// STRUCTURE
//  - Package uart_cmd_pkg: state enum localparams (IDLE, CMD, LEN, PAYLOAD,
//    CHK, HOLD), SOF default, command codes CMD_LOAD_N=8'h01,
//    CMD_LOAD_E=8'h02, CMD_LOAD_MSG=8'h03, CMD_START=8'h10.
//  - Sub-module uart_idle_timer: clear/enable counter, done at TO_CYC-1.
//  - Parser FSM, payload register file and checksum live in this module.
// TESTING
//  1 Frame A5 01 02 11 22 30 -> cmd_valid, code=01, len=02,
//    payload[15:0]=16'h2211, upper bytes 0, no errors.
//  2 Frame A5 01 02 11 22 31 -> err_chk 1-cycle pulse, no cmd_valid,
//    back in IDLE; following good frame accepted.
//  3 Frame A5 03 11 ... (LEN=17, MAX_LEN=16) -> err_len after LEN byte; the
//    remaining bytes are discarded until the next A5.
//  4 00 FF 5A A5 10 00 10 -> leading junk dropped, cmd_valid code=10 len=0.
//  5 cmd_ready low 20 cycles with another frame queued -> rd_uart=0, outputs
//    stable. Ready high -> IDLE, popping resumes next cycle.
//  6 A5 01 then FIFO empty for TO_CYC cycles -> err_timeout. Reset_n low
//    mid-payload -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Holds the parser state encoding, the default frame header and the RSA command codes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [7:0] SOF_DEFAULT  = 8'hA5;

  localparam logic [7:0] CMD_LOAD_N   = 8'h01;
  localparam logic [7:0] CMD_LOAD_E   = 8'h02;
  localparam logic [7:0] CMD_LOAD_MSG = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h10;

  // Running frame checksum: a plain XOR over CMD, LEN and the payload bytes.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter with synchronous clear and count enable.
// done is asserted while the count sits at TO_CYC-1; the count saturates there.
module uart_idle_timer #(
  parameter int TO_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt_r;
  logic          done_s;

  assign done_s = (cnt_r == LAST);
  assign done   = done_s;

  // Idle counter: cleared on request, advances while enabled until it reaches LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !done_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Pops bytes from a show-ahead UART rx FIFO and assembles SOF/CMD/LEN/payload/CHK frames.
// Good frames are held on a valid/ready port; checksum, length and timeout errors pulse for one cycle.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         DBIT    = 8,
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         TO_CYC  = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DBIT-1:0]      r_data,
  input  logic                 rx_empty,
  output logic                 rd_uart,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [7:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_timeout
);

  state_t               state_r, state_nxt;
  logic [7:0]           byte_s;
  logic                 pop_s, timer_active_s, timer_done_s, timeout_s;
  logic                 ld_code_s, ld_len_s, clr_pl_s, wr_pl_s;
  logic                 err_chk_nxt, err_len_nxt, err_to_nxt, valid_nxt;
  logic [7:0]           chk_r, chk_nxt;
  logic [7:0]           idx_r, idx_nxt;
  logic [7:0]           cmd_code_r, cmd_len_r;
  logic [8*MAX_LEN-1:0] cmd_payload_r;
  logic                 cmd_valid_r, err_chk_r, err_len_r, err_to_r;

  assign byte_s         = r_data;
  assign pop_s          = !rx_empty && (state_r != HOLD);
  assign timer_active_s = (state_r == CMD) || (state_r == LEN) ||
                          (state_r == PAYLOAD) || (state_r == CHK);
  assign timeout_s      = timer_active_s && timer_done_s;

  assign rd_uart     = pop_s;
  assign cmd_valid   = cmd_valid_r;
  assign cmd_code    = cmd_code_r;
  assign cmd_len     = cmd_len_r;
  assign cmd_payload = cmd_payload_r;
  assign err_chk     = err_chk_r;
  assign err_len     = err_len_r;
  assign err_timeout = err_to_r;

  uart_idle_timer #(.TO_CYC(TO_CYC)) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (pop_s || !timer_active_s),
    .en      (rx_empty),
    .done    (timer_done_s)
  );

  // Parser state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state and datapath strobes; a timeout overrides any byte popped in the same cycle.
  always_comb begin
    state_nxt   = state_r;
    ld_code_s   = 1'b0;
    ld_len_s    = 1'b0;
    clr_pl_s    = 1'b0;
    wr_pl_s     = 1'b0;
    err_chk_nxt = 1'b0;
    err_len_nxt = 1'b0;
    err_to_nxt  = 1'b0;
    valid_nxt   = cmd_valid_r;
    chk_nxt     = chk_r;
    idx_nxt     = idx_r;
    if (timeout_s) begin
      state_nxt  = IDLE;
      err_to_nxt = 1'b1;
    end else if (pop_s || (state_r == HOLD)) begin
      case (state_r)
        IDLE: begin
          if (byte_s == SOF) state_nxt = CMD;
          else               state_nxt = IDLE;
        end
        CMD: begin
          ld_code_s = 1'b1;
          chk_nxt   = byte_s;
          state_nxt = LEN;
        end
        LEN: begin
          chk_nxt = chk_fold(chk_r, byte_s);
          if (byte_s > 8'(MAX_LEN)) begin
            err_len_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            // Payload is cleared for zero-length frames too, so unused bytes always read 0.
            ld_len_s  = 1'b1;
            clr_pl_s  = 1'b1;
            idx_nxt   = 8'd0;
            state_nxt = (byte_s == 8'd0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_pl_s = 1'b1;
          chk_nxt = chk_fold(chk_r, byte_s);
          idx_nxt = idx_r + 8'd1;
          if (idx_r == (cmd_len_r - 8'd1)) state_nxt = CHK;
          else                             state_nxt = PAYLOAD;
        end
        CHK: begin
          if (byte_s == chk_r) begin
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end else begin
            err_chk_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
        HOLD: begin
          if (cmd_valid_r && cmd_ready) begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Frame fields, checksum, payload index, valid flag and one-cycle error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_code_r    <= 8'd0;
      cmd_len_r     <= 8'd0;
      cmd_payload_r <= '0;
      chk_r         <= 8'd0;
      idx_r         <= 8'd0;
      cmd_valid_r   <= 1'b0;
      err_chk_r     <= 1'b0;
      err_len_r     <= 1'b0;
      err_to_r      <= 1'b0;
    end else begin
      if (ld_code_s) cmd_code_r <= byte_s;
      if (ld_len_s)  cmd_len_r  <= byte_s;
      if (clr_pl_s) begin
        cmd_payload_r <= '0;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (wr_pl_s && (idx_r == 8'(i))) cmd_payload_r[8*i +: 8] <= byte_s;
        end
      end
      chk_r       <= chk_nxt;
      idx_r       <= idx_nxt;
      cmd_valid_r <= valid_nxt;
      err_chk_r   <= err_chk_nxt;
      err_len_r   <= err_len_nxt;
      err_to_r    <= err_to_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a queue models the show-ahead rx FIFO.
// Expected values are hand-computed frame fields, checksums and cycle counts.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int TO_CYC  = 40;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   r_data;
  logic         rx_empty;
  logic         rd_uart;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_code;
  logic [7:0]   cmd_len;
  logic [127:0] cmd_payload;
  logic         err_chk, err_len, err_timeout;

  logic [7:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_chk, n_len, n_to, n_vld;
  int took;

  always #5 clk = ~clk;

  uart_cmd_parser #(.DBIT(8), .MAX_LEN(MAX_LEN), .SOF(8'hA5), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_len(cmd_len),
    .cmd_payload(cmd_payload), .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (q.size() == 0) begin
      rx_empty = 1'b1;
      r_data   = 8'h00;
    end else begin
      rx_empty = 1'b0;
      r_data   = q[0];
    end
  endtask

  task automatic step();
    logic popped;
    popped = rd_uart;
    @(posedge clk);
    #1;
    if (popped && q.size() != 0) q.delete(0);
    drive();
    #1;
    if (err_chk)     n_chk++;
    if (err_len)     n_len++;
    if (err_timeout) n_to++;
    if (cmd_valid)   n_vld++;
  endtask

  task automatic send(input int n, input logic [255:0] v);
    for (int k = 0; k < n; k++) q.push_back(v[8*(n-1-k) +: 8]);
    drive();
    #1;
  endtask

  task automatic clear_counts();
    n_chk = 0; n_len = 0; n_to = 0; n_vld = 0;
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (cmd_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic release_frame();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_ready = 1'b0;
    clear_counts();
    drive();
    #2;
    check("rst_ctrl", {rd_uart, cmd_valid, err_chk, err_len, err_timeout}, 5'b0);
    check("rst_fields", {cmd_code, cmd_len}, 16'h0000);
    check("rst_payload", cmd_payload, 128'h0);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: good two-byte frame; CHK popped on step 6 gives valid after that edge
    send(6, 48'hA5_01_02_11_22_30);
    wait_valid(10, took);
    check("t1_latency", took, 6);
    check("t1_code", cmd_code, CMD_LOAD_N);
    check("t1_len", cmd_len, 8'h02);
    check("t1_payload", cmd_payload, 128'h2211);
    check("t1_errs", n_chk + n_len + n_to, 0);
    release_frame();
    check("t1_release", cmd_valid, 1'b0);

    // 2: bad checksum, then a good frame
    clear_counts();
    send(6, 48'hA5_01_02_11_22_31);
    for (int i = 0; i < 8; i++) step();
    check("t2_err_chk_cycles", n_chk, 1);
    check("t2_no_valid", n_vld, 0);
    send(5, 40'hA5_02_01_7E_7D);
    wait_valid(10, took);
    check("t2_recover_latency", took, 5);
    check("t2_fields", {cmd_code, cmd_len}, {CMD_LOAD_E, 8'h01});
    check("t2_payload", cmd_payload, 128'h7E);
    release_frame();

    // 3: LEN=17 rejected, trailing bytes dropped until the next SOF
    clear_counts();
    send(12, 96'hA5_03_11_01_02_03_04_A5_03_01_5A_58);
    wait_valid(20, took);
    check("t3_latency", took, 12);
    check("t3_err_len_cycles", n_len, 1);
    check("t3_other_errs", n_chk + n_to, 0);
    check("t3_fields", {cmd_code, cmd_len}, {CMD_LOAD_MSG, 8'h01});
    check("t3_payload", cmd_payload, 128'h5A);
    release_frame();

    // 3b: LEN=MAX_LEN boundary, payload 00..0F, XOR of payload is 0 so CHK=01^10
    clear_counts();
    send(20, 160'hA5_01_10_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_11);
    wait_valid(30, took);
    check("t3b_latency", took, 20);
    check("t3b_len", cmd_len, 8'h10);
    check("t3b_payload", cmd_payload, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t3b_errs", n_chk + n_len + n_to, 0);
    release_frame();

    // 4: leading junk, zero-length frame; payload must read back as zero
    send(7, 56'h00_FF_5A_A5_10_00_10);
    wait_valid(10, took);
    check("t4_latency", took, 7);
    check("t4_fields", {cmd_code, cmd_len}, {CMD_START, 8'h00});
    check("t4_payload", cmd_payload, 128'h0);
    release_frame();

    // 5: backpressure with a second frame queued
    send(9, 72'hA5_10_00_10_A5_01_01_33_33);
    wait_valid(10, took);
    check("t5_latency", took, 4);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t5_hold", {rd_uart, cmd_valid, cmd_code, cmd_len, 8'(q.size())},
            {1'b0, 1'b1, 8'h10, 8'h00, 8'd5});
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("t5_release", {cmd_valid, rd_uart, 8'(q.size())}, {1'b0, 1'b1, 8'd5});
    wait_valid(10, took);
    check("t5_second_latency", took, 5);
    check("t5_second_fields", {cmd_code, cmd_len}, {8'h01, 8'h01});
    check("t5_second_payload", cmd_payload, 128'h33);
    release_frame();

    // 6: stall after CMD; timeout TO_CYC edges after the last pop
    clear_counts();
    send(2, 16'hA5_01);
    took = -1;
    for (int i = 1; i <= TO_CYC + 10; i++) begin
      step();
      if (err_timeout) begin
        took = i;
        break;
      end
    end
    check("t6_timeout_latency", took, TO_CYC + 2);
    for (int i = 0; i < 2 * TO_CYC; i++) step();
    check("t6_timeout_cycles", n_to, 1);
    check("t6_other", {n_chk[7:0], n_len[7:0], cmd_valid}, 17'h0);

    // 6b: async reset mid-payload
    clear_counts();
    send(5, 40'hA5_03_04_01_02);
    for (int i = 0; i < 5; i++) step();
    check("t6b_mid_len", cmd_len, 8'h04);
    reset_n = 1'b0;
    q.delete();
    drive();
    #1;
    check("t6b_rst_ctrl", {rd_uart, cmd_valid, err_chk, err_len, err_timeout}, 5'b0);
    check("t6b_rst_fields", {cmd_code, cmd_len}, 16'h0000);
    check("t6b_rst_payload", cmd_payload, 128'h0);
    step(); step(); step();
    check("t6b_no_err", n_chk + n_len + n_to, 0);
    reset_n = 1'b1;
    step();
    send(6, 48'hA5_01_02_11_22_30);
    wait_valid(10, took);
    check("t6b_idle_after_reset", took, 6);
    check("t6b_payload", cmd_payload, 128'h2211);
    release_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
